// File: rtl/len_arbiter.sv
// Two-requester round-robin front end for a shared bit-length unit.
// Each operation is latched, issued to the unit, and completed with either
// the unit's result or a timeout error. A new request can be arbitrated in
// the same cycle that the previous completion pulses done.
module len_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] num0,
  input  logic [63:0] num1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  len_out,
  output logic        err,
  output logic        busy,
  output logic        gl_md_start,
  output logic [63:0] gl_num,
  input  logic [7:0]  gl_len_in,
  input  logic        gl_md_end
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      r_state, w_state_d;
  logic        r_grant;    // requester owning the operation in flight
  logic        r_last;     // requester served most recently
  logic [63:0] r_operand;
  logic [7:0]  r_cnt;
  logic [7:0]  r_len;
  logic        r_err;
  logic        r_done0, r_done1;

  logic        w_any;
  logic        w_win;
  logic        w_timeout;
  logic        w_complete;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_any = req0 | req1;
    w_win = 1'b0;
    if (req0 && req1) begin
      w_win = ~r_last;
    end else begin
      w_win = req1;
    end
  end

  // Next-state logic; completion is a result strobe or the final allowed WAIT cycle.
  always_comb begin
    w_state_d  = r_state;
    w_timeout  = (r_cnt == TimeoutLast);
    w_complete = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any) w_state_d = StIssue;
      end
      StIssue: begin
        w_state_d = StWait;
      end
      StWait: begin
        // gl_md_end takes priority over a simultaneous timeout
        if (gl_md_end || w_timeout) begin
          w_complete = 1'b1;
          w_state_d  = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Operand/grant capture, WAIT counter and registered completion outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant   <= 1'b0;
      r_last    <= 1'b1;  // requester 0 wins the first tie
      r_operand <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == StIdle && w_any) begin
        r_operand <= w_win ? num1 : num0;
        r_grant   <= w_win;
      end
      if (r_state == StIssue) begin
        r_cnt <= '0;
      end else if (r_state == StWait && !w_complete) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_complete) begin
        r_len   <= gl_md_end ? gl_len_in : 8'd0;
        r_err   <= ~gl_md_end;
        r_done0 <= ~r_grant;
        r_done1 <= r_grant;
        r_last  <= r_grant;
      end
    end
  end

  assign ack0        = (r_state == StIssue) && !r_grant;
  assign ack1        = (r_state == StIssue) && r_grant;
  assign gl_md_start = (r_state == StIssue);
  assign busy        = (r_state != StIdle);
  assign gl_num      = r_operand;
  assign len_out     = r_len;
  assign err         = r_err;
  assign done0       = r_done0;
  assign done1       = r_done1;

endmodule

// File: tb/tb_len_arbiter.sv
// Self-checking bench for len_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_len_arbiter;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [63:0] num0 = '0, num1 = '0;
  logic        ack0, ack1, done0, done1, err, busy, gl_md_start;
  logic [7:0]  len_out;
  logic [63:0] gl_num;
  logic [7:0]  gl_len_in = '0;
  logic        gl_md_end = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Unit-model and requester behaviour knobs.
  int unsigned u_delay    = 1;  // cycles from start to end; 0 = never answer
  bit          u_random   = 1'b0;
  bit          u_spurious = 1'b0;
  bit          auto_req   = 1'b0;

  len_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0       (req0),
    .req1       (req1),
    .num0       (num0),
    .num1       (num1),
    .ack0       (ack0),
    .ack1       (ack1),
    .done0      (done0),
    .done1      (done1),
    .len_out    (len_out),
    .err        (err),
    .busy       (busy),
    .gl_md_start(gl_md_start),
    .gl_num     (gl_num),
    .gl_len_in  (gl_len_in),
    .gl_md_end  (gl_md_end)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bitlen(input logic [63:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < 64; i++) if (v[i]) n = 8'(i + 1);
    return n;
  endfunction

  function automatic logic [63:0] rnd_num();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v >> $urandom_range(0, 64);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Inputs change 2 time units after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30 && busy; k++) cyc();
    chk("reach_idle", busy, 1'b0);
  endtask

  // Shared length unit: answers u_delay cycles after the start strobe.
  initial begin : unit
    int unsigned cd;
    logic [63:0] opnd;
    cd   = 0;
    opnd = '0;
    forever begin
      cyc();
      gl_md_end = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          gl_md_end = 1'b1;
          gl_len_in = bitlen(opnd);
        end
      end else if (u_spurious && $urandom_range(0, 3) == 0) begin
        gl_md_end = 1'b1;
        gl_len_in = 8'($urandom);
      end
      if (gl_md_start) begin
        cd   = u_random ? $urandom_range(1, TIMEOUT + 2) : u_delay;
        opnd = gl_num;
      end
    end
  end

  // Random requesters: hold req until ack, then either stop or continue with a fresh operand.
  initial begin : requesters
    forever begin
      cyc();
      if (auto_req) begin
        if (ack0) begin
          if ($urandom_range(0, 1) == 1) num0 = rnd_num();
          else req0 = 1'b0;
        end else if (!req0 && $urandom_range(0, 2) == 0) begin
          num0 = rnd_num();
          req0 = 1'b1;
        end
        if (ack1) begin
          if ($urandom_range(0, 1) == 1) num1 = rnd_num();
          else req1 = 1'b0;
        end else if (!req1 && $urandom_range(0, 2) == 0) begin
          num1 = rnd_num();
          req1 = 1'b1;
        end
      end
    end
  end

  // Reference model: on each falling edge, compare then predict the next cycle
  // from the inputs the DUT will sample at the coming rising edge.
  initial begin : model
    logic        m_busy, m_who, m_last;
    int unsigned m_phase, m_wait;
    logic        e_ack0, e_ack1, e_start, e_done0, e_done1, e_err, e_busy;
    logic [7:0]  e_len;
    logic [63:0] e_num;
    m_busy = 1'b0; m_who = 1'b0; m_last = 1'b1; m_phase = 0; m_wait = 0;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_start = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
    e_err = 1'b0; e_busy = 1'b0; e_len = '0; e_num = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_busy = 1'b0; m_who = 1'b0; m_last = 1'b1; m_phase = 0; m_wait = 0;
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_start = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
        e_err = 1'b0; e_busy = 1'b0; e_len = '0; e_num = '0;
      end
      chk("m_ack0", ack0, e_ack0);
      chk("m_ack1", ack1, e_ack1);
      chk("m_start", gl_md_start, e_start);
      chk("m_done0", done0, e_done0);
      chk("m_done1", done1, e_done1);
      chk("m_err", err, e_err);
      chk("m_busy", busy, e_busy);
      chk("m_len", len_out, e_len);
      chk("m_gl_num", gl_num, e_num);
      if (rstn) begin
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_start = 1'b0;
        e_done0 = 1'b0; e_done1 = 1'b0; e_err = 1'b0;
        if (!m_busy) begin
          if (req0 || req1) begin
            m_who   = (req0 && req1) ? ~m_last : req1;
            m_busy  = 1'b1;
            m_phase = 1;
            e_num   = m_who ? num1 : num0;
            e_ack0  = !m_who;
            e_ack1  = m_who;
            e_start = 1'b1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
          m_wait  = 1;
        end else begin
          if (gl_md_end || m_wait == TIMEOUT) begin
            e_len   = gl_md_end ? gl_len_in : 8'd0;
            e_err   = !gl_md_end;
            e_done0 = !m_who;
            e_done1 = m_who;
            m_last  = m_who;
            m_busy  = 1'b0;
          end else begin
            m_wait++;
          end
        end
        e_busy = m_busy;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w;
    rstn = 1'b0;
    repeat (2) cyc();
    rstn = 1'b1;
    cyc();

    // Single request, unit answers one cycle after start.
    u_delay = 1;
    req0 = 1'b1; num0 = 64'h9;
    cyc();
    chk("single_ack0", ack0, 1'b1);
    chk("single_start", gl_md_start, 1'b1);
    chk("single_busy", busy, 1'b1);
    req0 = 1'b0;
    cyc();
    chk("single_start_drop", gl_md_start, 1'b0);
    chk("single_ack_drop", ack0, 1'b0);
    cyc();
    chk("single_done0", done0, 1'b1);
    chk("single_len", len_out, 8'd4);
    chk("single_err", err, 1'b0);
    chk("single_idle", busy, 1'b0);
    cyc();
    chk("single_done_pulse", done0, 1'b0);
    chk("single_len_held", len_out, 8'd4);

    // Tie from reset: requester 0 first, then requester 1.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; num0 = 64'h1; num1 = 64'h8000_0000_0000_0000;
    cyc();
    chk("tie_ack0", ack0, 1'b1);
    chk("tie_no_ack1", ack1, 1'b0);
    req0 = 1'b0;
    cyc();
    cyc();
    chk("tie_done0", done0, 1'b1);
    chk("tie_len0", len_out, 8'd1);
    cyc();
    chk("tie_ack1", ack1, 1'b1);
    req1 = 1'b0;
    cyc();
    cyc();
    chk("tie_done1", done1, 1'b1);
    chk("tie_len1", len_out, 8'd64);

    // Both requesters continuously active: grants must alternate.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; num0 = rnd_num(); num1 = rnd_num();
    for (int op = 0; op < 4; op++) begin
      w = -1;
      for (int k = 0; k < 10 && w < 0; k++) begin
        cyc();
        if (ack0) w = 0;
        else if (ack1) w = 1;
      end
      chk("rr_grant", w, op % 2);
      if (w == 0) num0 = rnd_num();
      else if (w == 1) num1 = rnd_num();
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // Unit never answers: error completion after TIMEOUT WAIT cycles.
    do_reset();
    u_delay = 0;
    req0 = 1'b1; num0 = 64'h55;
    cyc();
    req0 = 1'b0;
    repeat (TIMEOUT) cyc();
    chk("to_not_yet", done0, 1'b0);
    chk("to_still_busy", busy, 1'b1);
    cyc();
    chk("to_done0", done0, 1'b1);
    chk("to_err", err, 1'b1);
    chk("to_len", len_out, 8'd0);
    chk("to_idle", busy, 1'b0);
    cyc();
    chk("to_err_pulse", err, 1'b0);

    // Result arrives in the very cycle the timeout would fire.
    u_delay = TIMEOUT;
    req1 = 1'b1; num1 = 64'hFF;
    cyc();
    req1 = 1'b0;
    repeat (TIMEOUT + 1) cyc();
    chk("race_done1", done1, 1'b1);
    chk("race_err", err, 1'b0);
    chk("race_len", len_out, 8'd8);

    // Reset during WAIT, then a stale result arrives while idle.
    u_delay = 3;
    req0 = 1'b1; num0 = 64'h3;
    cyc();
    req0 = 1'b0;
    cyc();
    chk("mid_busy_before", busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_len", len_out, 8'd0);
    chk("mid_rst_num", gl_num, 64'h0);
    cyc();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("mid_no_done", {done0, done1, busy}, 3'b000);
    end
    u_delay = 1;
    req0 = 1'b1; req1 = 1'b1; num0 = 64'h3; num1 = 64'h7;
    cyc();
    chk("mid_ack0", ack0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    cyc();
    chk("mid_done0", done0, 1'b1);
    chk("mid_len", len_out, 8'd2);

    // Randomized traffic with random unit latency and stray strobes.
    u_random = 1'b1; u_spurious = 1'b1; auto_req = 1'b1;
    repeat (1500) cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    repeat (1500) cyc();
    auto_req = 1'b0;
    cyc();
    req0 = 1'b0; req1 = 1'b0; u_spurious = 1'b0;
    wait_idle();
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/len_arbiter.md
LEN_ARBITER -- requirements
Module: len_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8, max number of WAIT cycles allowed for gl_md_end before an error completion (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 req0 / req1  input  1 each  request level from requester 0 / 1; held high until the matching ack.
REQ-005 num0 / num1  input  64 each  operand from requester 0 / 1; stable while the matching req is high.
REQ-006 ack0 / ack1  output  1 each  one-cycle pulse: operand latched, requester may drop req and change num.
REQ-007 done0 / done1  output  1 each  one-cycle pulse: result for that requester is valid on len_out/err.
REQ-008 len_out  output  8  bit length of the granted operand (registered, held until the next completion).
REQ-009 err  output  1  high with done0/done1 when the completion is a timeout; otherwise 0.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 gl_md_start  output  1  start strobe to the shared length unit.
REQ-012 gl_num  output  64  operand to the shared length unit.
REQ-013 gl_len_in  input  8  result from the shared length unit.
REQ-014 gl_md_end  input  1  completion strobe from the shared length unit.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT; encoding is free.
REQ-016 IDLE: if any req is high, latch the winner's num into the operand register, record the winner in a grant register, pulse its ack in the next cycle and move to ISSUE; otherwise stay in IDLE.
REQ-017 Arbitration is round-robin via a last-grant register: if only one req is high, that requester wins; if both are high, the requester not granted last wins.
REQ-018 ISSUE: gl_md_start = 1 for exactly this one cycle, then unconditionally move to WAIT; gl_md_start = 0 in every other state.
REQ-019 gl_num always drives the operand register, which holds its value until the next grant.
REQ-020 WAIT: on gl_md_end = 1, register len_out <= gl_len_in, err <= 0, pulse done for the granted requester, update last-grant, and move to IDLE.
REQ-021 WAIT timeout: an 8-bit counter clears on entry to WAIT and increments on each WAIT cycle without gl_md_end.
REQ-022 When the counter equals TIMEOUT-1 and gl_md_end = 0: register len_out <= 0, err <= 1, pulse done for the granted requester, update last-grant, and move to IDLE.
REQ-023 If gl_md_end and the timeout condition occur in the same cycle, gl_md_end wins (normal completion, err = 0).
REQ-024 gl_md_end seen in IDLE or ISSUE is ignored: no state change and no output change.
REQ-025 Timing (req seen in IDLE at cycle 0):
- ack in cycle 1 (ISSUE, gl_md_start high);
- gl_md_end expected in cycle 2;
- done, len_out and err valid in cycle 3, with state IDLE in cycle 3.
REQ-026 A new req may be arbitrated in the same cycle that done is high, so steady-state throughput is one operation per 3 cycles.
REQ-027 Requests are never accepted outside IDLE; a req raised while busy waits without being lost.
REQ-028 ack0/ack1 and done0/done1 are never high in the same cycle for both requesters; each pulse is exactly one cycle.

Reset
REQ-029 On rstn = 0, immediately and asynchronously:
- state = IDLE, last-grant = requester 1 (requester 0 wins the first tie);
- operand register = 0, counter = 0, len_out = 0, err = 0;
- all ack/done = 0, busy = 0, gl_md_start = 0.
REQ-030 Reset mid-operation abandons the operation with no done pulse; a gl_md_end arriving after reset release while in IDLE is ignored per REQ-024.

Verification
REQ-031 req0 = 1, num0 = 64'h9, unit model answers 1 cycle after start -> ack0 in cycle 1, gl_md_start high in cycle 1 only, done0 in cycle 3, len_out = 4, err = 0.
REQ-032 req0 and req1 high together from reset, num0 = 64'h1, num1 = 64'h8000_0000_0000_0000 -> requester 0 served first (len_out 1), then requester 1 (len_out 64); done0 in cycle 3, done1 in cycle 6.
REQ-033 Both reqs kept high with fresh operands for 4 operations -> grants alternate 0, 1, 0, 1 with no starvation.
REQ-034 Unit model never asserts gl_md_end, TIMEOUT = 8 -> done pulse with err = 1 and len_out = 0 after 8 WAIT cycles; then IDLE.
REQ-035 Model asserts gl_md_end in the same cycle as the timeout condition -> err = 0 and len_out = gl_len_in.
REQ-036 rstn pulsed low during WAIT, then late gl_md_end -> outputs go to reset values immediately; no done pulse; the next req is served normally by requester 0.
